// File: rtl/lut_fngen_if.sv
// Config stream and evaluation port bundle for lut_fngen.
// The master drives the stream and the inputs; the slave returns the results.
interface lut_fngen_if #(
  parameter int K = 4
);
  logic         cfg_start;
  logic         cfg_valid;
  logic         cfg_bit;
  logic         cfg_ready;
  logic         cfg_done;
  logic         cfg_err;
  logic         in_valid;
  logic [K-1:0] in_vars;
  logic         f;
  logic         f_valid;

  modport master (
    output cfg_start, cfg_valid, cfg_bit,
    output in_valid, in_vars,
    input  cfg_ready, cfg_done, cfg_err,
    input  f, f_valid
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_bit,
    input  in_valid, in_vars,
    output cfg_ready, cfg_done, cfg_err,
    output f, f_valid
  );
endinterface

// File: rtl/lut_fngen.sv
// K-input LUT function generator with a serially loaded shadow table.
// Define LUT_PARITY_EN to append an even-parity beat checked before commit.
module lut_fngen #(
  parameter int K = 4,
  parameter logic [(1<<K)-1:0] INIT = '0
) (
  input logic       clk,
  input logic       resetn,
  lut_fngen_if.slave bus
);
  localparam int N = 1 << K;
`ifdef LUT_PARITY_EN
  localparam int L = N + 1;
`else
  localparam int L = N;
`endif

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] act_q;
  logic [N-1:0] shd_q, shd_d;
  logic [K:0]   cnt_q;
  logic         cfgd_q;
  logic         done_q;
  logic         f_q, fv_q;
  logic         ready;
  logic         beat, last;
  logic         par_ok;
  logic         commit, reject;

  // A start request outranks a beat landing on the same edge.
  assign beat = bus.cfg_valid & ready & ~bus.cfg_start;
  assign last = beat && (cnt_q == (K+1)'(L - 1));

`ifdef LUT_PARITY_EN
  logic par_q;
  logic err_q;
  assign par_ok = ~(par_q ^ bus.cfg_bit);
  assign bus.cfg_err = err_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      par_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (bus.cfg_start)
        par_q <= 1'b0;
      else if (beat)
        par_q <= par_q ^ bus.cfg_bit;
      err_q <= reject;
    end
  end
`else
  assign par_ok = 1'b1;
  assign bus.cfg_err = 1'b0;
`endif

  assign commit = last & par_ok;
  assign reject = last & ~par_ok;

  // Shadow including the bit arriving this cycle, so commit sees it.
  always_comb begin
    shd_d = shd_q;
    if (beat && cnt_q < (K+1)'(N))
      shd_d[cnt_q[K-1:0]] = bus.cfg_bit;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      bus.cfg_start: state_d = LOAD;
      commit:        state_d = RUN;
      reject:        state_d = cfgd_q ? RUN : IDLE;
      default:       state_d = state_q;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    unique case (state_q)
      LOAD:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      act_q  <= INIT;
      shd_q  <= '0;
      cnt_q  <= '0;
      cfgd_q <= 1'b0;
      done_q <= 1'b0;
      f_q    <= 1'b0;
      fv_q   <= 1'b0;
    end else begin
      if (bus.cfg_start) begin
        cnt_q <= '0;
      end else if (beat) begin
        cnt_q <= cnt_q + 1'b1;
        shd_q <= shd_d;
      end
      if (commit) begin
        act_q  <= shd_d;
        cfgd_q <= 1'b1;
      end
      done_q <= commit;
      // Reads the pre-commit table when commit shares this edge.
      fv_q <= bus.in_valid;
      if (bus.in_valid)
        f_q <= act_q[bus.in_vars];
    end
  end

  assign bus.cfg_ready = ready;
  assign bus.cfg_done  = done_q;
  assign bus.f         = f_q;
  assign bus.f_valid   = fv_q;
endmodule

// File: tb/tb_lut_fngen.sv
// Randomized self-checking bench for lut_fngen (K=4, INIT=0).
// Holds the expected active table and last result as plain variables.
module tb_lut_fngen;
`ifdef LUT_PARITY_EN
  localparam int  L   = 17;
  localparam bit  PEN = 1'b1;
`else
  localparam int  L   = 16;
  localparam bit  PEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit [15:0] model_tbl = 16'h0000;
  bit        f_exp = 1'b0;

  lut_fngen_if #(.K(4)) ifc ();

  lut_fngen #(.K(4), .INIT(16'h0000)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ifc.cfg_start = 0;
    ifc.cfg_valid = 0;
    ifc.cfg_bit   = 0;
    ifc.in_valid  = 0;
    ifc.in_vars   = '0;
    resetn = 0;
    tick();
    tick();
    n_chk++;
    if ({ifc.cfg_ready, ifc.cfg_done, ifc.cfg_err, ifc.f, ifc.f_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outs got=%b want=00000",
        {ifc.cfg_ready, ifc.cfg_done, ifc.cfg_err, ifc.f, ifc.f_valid});
    end
    resetn = 1;
    tick();
    ifc.in_valid = 1;
    ifc.in_vars  = 4'hA;
    tick();
    ifc.in_valid = 0;
    n_chk++;
    if (ifc.f !== 1'b0 || ifc.f_valid !== 1'b1 || ifc.cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL init_eval got f=%b fv=%b rdy=%b want 0 1 0",
        ifc.f, ifc.f_valid, ifc.cfg_ready);
    end
    f_exp = 1'b0;
  endtask

  // Loads tbl (plus pbit when parity is built in). abort>0 stops early.
  task automatic do_load(input bit [15:0] tbl, input bit pbit,
                         input int stall, input int abort);
    int acc = 0;
    int guard = 0;
    bit v;
    bit ok;
    ifc.cfg_start = 1;
    ifc.cfg_valid = 1;
    ifc.cfg_bit   = 1;
    tick();
    ifc.cfg_start = 0;
    ifc.cfg_valid = 0;
    n_chk++;
    if (ifc.cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load_ready got=%b want=1", ifc.cfg_ready);
    end
    while (acc < L && guard < 2000) begin
      v = ($urandom_range(99) >= stall);
      ifc.cfg_valid = v;
      ifc.cfg_bit   = (acc < 16) ? tbl[acc] : pbit;
      tick();
      if (v) acc++;
      guard++;
      if (abort > 0 && acc == abort) begin
        ifc.cfg_valid = 0;
        return;
      end
      if (acc < L && (ifc.cfg_done !== 1'b0 || ifc.cfg_ready !== 1'b1)) begin
        n_chk++;
        n_fail++;
        $display("FAIL load_mid beat=%0d done=%b rdy=%b want 0 1",
          acc, ifc.cfg_done, ifc.cfg_ready);
      end
    end
    ifc.cfg_valid = 0;
    ok = !PEN || ((^tbl) ^ pbit) == 1'b0;
    n_chk++;
    if (acc != L || ifc.cfg_done !== ok || ifc.cfg_err !== (PEN && !ok)
        || ifc.cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL load_end beats=%0d done=%b err=%b rdy=%b want %0d %b %b 0",
        acc, ifc.cfg_done, ifc.cfg_err, ifc.cfg_ready, L, ok, PEN && !ok);
    end
    if (ok) model_tbl = tbl;
    tick();
    n_chk++;
    if (ifc.cfg_done !== 1'b0 || ifc.cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse_len done=%b err=%b want 0 0", ifc.cfg_done, ifc.cfg_err);
    end
  endtask

  task automatic test_load_sweep();
    do_load(16'h73F0, ^(16'h73F0), 0, 0);
    for (int i = 0; i < 16; i++) begin
      ifc.in_valid = 1;
      ifc.in_vars  = 4'(i);
      tick();
      n_chk++;
      if (ifc.f !== model_tbl[i] || ifc.f_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL sweep v=%0d got f=%b fv=%b want %b 1",
          i, ifc.f, ifc.f_valid, model_tbl[i]);
      end
    end
    ifc.in_valid = 0;
    f_exp = model_tbl[15];
  endtask

  task automatic test_commit_edge();
    bit [15:0] nt = 16'hFFFF;
    bit        e;
    int        acc = 0;
    ifc.in_valid  = 1;
    ifc.in_vars   = 4'h0;
    ifc.cfg_start = 1;
    tick();
    ifc.cfg_start = 0;
    n_chk++;
    if (ifc.f !== model_tbl[0]) begin
      n_fail++;
      $display("FAIL edge_start got=%b want=%b", ifc.f, model_tbl[0]);
    end
    while (acc < L) begin
      ifc.cfg_valid = 1;
      ifc.cfg_bit   = (acc < 16) ? nt[acc] : ^nt;
      e = model_tbl[0];
      tick();
      acc++;
      if (acc == L) model_tbl = nt;
      n_chk++;
      if (ifc.f !== e || ifc.f_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL edge_eval beat=%0d got f=%b fv=%b want %b 1",
          acc, ifc.f, ifc.f_valid, e);
      end
    end
    ifc.cfg_valid = 0;
    tick();
    ifc.in_valid = 0;
    n_chk++;
    if (ifc.f !== 1'b1 || ifc.cfg_done !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_after got f=%b done=%b want 1 0", ifc.f, ifc.cfg_done);
    end
    f_exp = 1'b1;
  endtask

  task automatic test_restart_stall();
    do_load(16'($urandom), 1'b0, 40, 7);
    do_load(16'h0001, 1'b1, 40, 0);
    for (int i = 0; i < 2; i++) begin
      ifc.in_valid = 1;
      ifc.in_vars  = 4'(i);
      tick();
      n_chk++;
      if (ifc.f !== (i == 0)) begin
        n_fail++;
        $display("FAIL restart v=%0d got=%b want=%b", i, ifc.f, i == 0);
      end
    end
    ifc.in_valid = 0;
    f_exp = 1'b0;
  endtask

  task automatic test_midload_reset();
    do_load(16'hFFFF, 1'b0, 0, 9);
    ifc.in_valid = 1;
    ifc.in_vars  = 4'h3;
    resetn = 0;
    #1;
    n_chk++;
    if ({ifc.cfg_ready, ifc.cfg_done, ifc.cfg_err, ifc.f, ifc.f_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL midload_rst got=%b want=00000",
        {ifc.cfg_ready, ifc.cfg_done, ifc.cfg_err, ifc.f, ifc.f_valid});
    end
    ifc.in_valid = 0;
    tick();
    resetn = 1;
    model_tbl = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      ifc.in_valid = 1;
      ifc.in_vars  = 4'($urandom);
      tick();
      n_chk++;
      if (ifc.f !== 1'b0 || ifc.f_valid !== 1'b1 || ifc.cfg_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL post_rst got f=%b fv=%b rdy=%b want 0 1 0",
          ifc.f, ifc.f_valid, ifc.cfg_ready);
      end
    end
    ifc.in_valid = 0;
    f_exp = 1'b0;
  endtask

  task automatic test_random();
    bit [15:0] t;
    bit        iv;
    bit [3:0]  vv;
    for (int r = 0; r < 4; r++) begin
      t = 16'($urandom);
      do_load(t, ^t, 35, 0);
      for (int c = 0; c < 24; c++) begin
        iv = (c == 0) || ($urandom_range(3) != 0);
        vv = 4'($urandom);
        ifc.in_valid = iv;
        ifc.in_vars  = vv;
        if (iv) f_exp = model_tbl[vv];
        tick();
        n_chk++;
        if (ifc.f !== f_exp || ifc.f_valid !== iv) begin
          n_fail++;
          $display("FAIL rand r=%0d c=%0d got f=%b fv=%b want %b %b",
            r, c, ifc.f, ifc.f_valid, f_exp, iv);
        end
      end
      ifc.in_valid = 0;
    end
  endtask

  task automatic test_parity();
    bit [15:0] old = model_tbl;
    do_load(16'h0001, 1'b0, 20, 0);
    for (int i = 0; i < 16; i++) begin
      ifc.in_valid = 1;
      ifc.in_vars  = 4'(i);
      tick();
      n_chk++;
      if (ifc.f !== old[i]) begin
        n_fail++;
        $display("FAIL parity_keep v=%0d got=%b want=%b", i, ifc.f, old[i]);
      end
    end
    ifc.in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_load_sweep();
    test_commit_edge();
    test_restart_stall();
    test_midload_reset();
    test_random();
    if (PEN) test_parity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
